// File: rtl/aes_seq_ctrl_if.sv
// Bus bundle between the host/wrapper environment and the AES sequencer.
//   Request channel  : req_valid/req_ready plus key, block, keylen, encdec and rekey fields.
//   Result channel   : res_valid/res_ready plus res_data and res_err.
//   Status           : busy.
//   Wrapper bus      : control opcode and write_data toward the wrapper, data_out back from it.
// Modports: slave = the sequencer, master = its environment (host and wrapper).
interface aes_seq_ctrl_if;
    logic         req_valid;
    logic         req_ready;
    logic [255:0] req_key;
    logic [127:0] req_block;
    logic         req_keylen;
    logic         req_encdec;
    logic         req_rekey;
    logic         res_valid;
    logic         res_ready;
    logic [127:0] res_data;
    logic         res_err;
    logic         busy;
    logic [3:0]   control;
    logic [15:0]  write_data;
    logic [7:0]   data_out;

    modport slave (
        input  req_valid, req_key, req_block, req_keylen, req_encdec, req_rekey, res_ready,
               data_out,
        output req_ready, res_valid, res_data, res_err, busy, control, write_data
    );

    modport master (
        output req_valid, req_key, req_block, req_keylen, req_encdec, req_rekey, res_ready,
               data_out,
        input  req_ready, res_valid, res_data, res_err, busy, control, write_data
    );
endinterface

// File: rtl/aes_seq_ctrl.sv
// Sequencer that runs one AES job on the wrapper's control/write/read bus for a single requester:
// config, key load, init, poll ready, block load, next, poll valid, read 16 result bytes, return.
// Key load and expansion are skipped when key and config match the last loaded set.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (shared with the wrapper)
//   bus      aes_seq_ctrl_if.slave: request/result handshakes, busy, wrapper bus
module aes_seq_ctrl #(
    parameter int unsigned GUARD   = 4,    // NOPs after an init/next pulse before first poll
    parameter int unsigned TIMEOUT = 1023, // max cycles in a wait state
    parameter int unsigned RD_LAT  = 1     // RESULT_OUT issue to data_out latency (1..2)
) (
    input  logic          clk,
    input  logic          reset_n,
    aes_seq_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        StIdle, StCfg, StKey, StInit, StGuardRdy, StWaitRdy,
        StBlk, StNext, StGuardVal, StWaitVal, StRead, StDone
    } state_e;

    localparam logic [3:0] CtlNop     = 4'd0;
    localparam logic [3:0] CtlBlockWe = 4'd1;
    localparam logic [3:0] CtlKeyWe   = 4'd2;
    localparam logic [3:0] CtlStatus  = 4'd3;
    localparam logic [3:0] CtlConfig  = 4'd4;
    localparam logic [3:0] CtlCtrl    = 4'd5;
    localparam logic [3:0] CtlResult  = 4'd6;

    localparam logic [4:0] GuardLast = 5'(GUARD == 0 ? 0 : GUARD - 1);
    localparam logic [4:0] RdLat     = 5'(RD_LAT);
    localparam logic [4:0] ReadLast  = 5'(15 + RD_LAT);
    localparam logic [9:0] TmoLast   = 10'(TIMEOUT - 1);

    state_e         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [9:0]     tmo_q, tmo_d;
    logic [255:0]   key_q, key_d;
    logic [127:0]   blk_q, blk_d;
    logic           keylen_q, keylen_d;
    logic           encdec_q, encdec_d;
    logic [255:0]   ld_key_q, ld_key_d;
    logic           ld_keylen_q, ld_keylen_d;
    logic           ld_encdec_q, ld_encdec_d;
    logic           key_loaded_q, key_loaded_d;
    logic           res_valid_q, res_valid_d;
    logic           res_err_q, res_err_d;
    logic [127:0]   res_data_q, res_data_d;
    logic [3:0]     control_q, control_d;
    logic [15:0]    write_data_q, write_data_d;
    logic           rekey;
    logic           abort;

    assign rekey = bus.req_rekey | ~key_loaded_q | (bus.req_key != ld_key_q) |
                   (bus.req_keylen != ld_keylen_q) | (bus.req_encdec != ld_encdec_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        key_d        = key_q;
        blk_d        = blk_q;
        keylen_d     = keylen_q;
        encdec_d     = encdec_q;
        ld_key_d     = ld_key_q;
        ld_keylen_d  = ld_keylen_q;
        ld_encdec_d  = ld_encdec_q;
        key_loaded_d = key_loaded_q;
        res_valid_d  = res_valid_q;
        res_err_d    = res_err_q;
        res_data_d   = res_data_q;
        abort        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    key_d    = bus.req_key;
                    blk_d    = bus.req_block;
                    keylen_d = bus.req_keylen;
                    encdec_d = bus.req_encdec;
                    cnt_d    = '0;
                    state_d  = rekey ? StCfg : StBlk;
                end
            end
            StCfg: begin
                cnt_d   = '0;
                state_d = StKey;
            end
            StKey: begin
                if (cnt_q == 5'd15) begin
                    cnt_d   = '0;
                    state_d = StInit;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StInit: begin
                cnt_d   = '0;
                tmo_d   = '0;
                state_d = (GUARD == 0) ? StWaitRdy : StGuardRdy;
            end
            StGuardRdy: begin
                if (cnt_q == GuardLast) begin
                    cnt_d   = '0;
                    state_d = StWaitRdy;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StWaitRdy: begin
                if (bus.data_out[0]) begin
                    key_loaded_d = 1'b1;
                    ld_key_d     = key_q;
                    ld_keylen_d  = keylen_q;
                    ld_encdec_d  = encdec_q;
                    cnt_d        = '0;
                    state_d      = StBlk;
                end else if (tmo_q == TmoLast) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + 10'd1;
                end
            end
            StBlk: begin
                if (cnt_q == 5'd7) begin
                    cnt_d   = '0;
                    state_d = StNext;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StNext: begin
                cnt_d   = '0;
                tmo_d   = '0;
                state_d = (GUARD == 0) ? StWaitVal : StGuardVal;
            end
            StGuardVal: begin
                if (cnt_q == GuardLast) begin
                    cnt_d   = '0;
                    state_d = StWaitVal;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StWaitVal: begin
                if (bus.data_out[1]) begin
                    cnt_d   = '0;
                    state_d = StRead;
                end else if (tmo_q == TmoLast) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + 10'd1;
                end
            end
            StRead: begin
                // Bytes arrive RD_LAT cycles behind their issue; shifting in from the bottom
                // leaves the first byte read at [127:120] once all 16 are in.
                if (cnt_q >= RdLat) begin
                    res_data_d = {res_data_q[119:0], bus.data_out};
                end
                if (cnt_q == ReadLast) begin
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b0;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StDone: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    res_err_d   = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Timeout: report an error result and force the next job through a full key load.
        if (abort) begin
            res_valid_d  = 1'b1;
            res_err_d    = 1'b1;
            res_data_d   = '0;
            key_loaded_d = 1'b0;
            state_d      = StDone;
        end

        // Bus outputs are registered, so they are decoded from the upcoming state and count.
        // For i in 0..15, 255-16i == {~i, 4'hf}; likewise 127-16i == {~i[2:0], 4'hf}.
        control_d    = CtlNop;
        write_data_d = '0;
        unique case (state_d)
            StCfg: begin
                control_d    = CtlConfig;
                write_data_d = {14'b0, keylen_d, encdec_d};
            end
            StKey: begin
                control_d    = CtlKeyWe;
                write_data_d = key_d[{~cnt_d[3:0], 4'hf} -: 16];
            end
            StInit: begin
                control_d    = CtlCtrl;
                write_data_d = 16'h0001;
            end
            StBlk: begin
                control_d    = CtlBlockWe;
                write_data_d = blk_d[{~cnt_d[2:0], 4'hf} -: 16];
            end
            StNext: begin
                control_d    = CtlCtrl;
                write_data_d = 16'h0002;
            end
            StWaitRdy, StWaitVal: control_d = CtlStatus;
            StRead: begin
                if (cnt_d < 5'd16) control_d = CtlResult;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            tmo_q        <= '0;
            key_q        <= '0;
            blk_q        <= '0;
            keylen_q     <= 1'b0;
            encdec_q     <= 1'b0;
            ld_key_q     <= '0;
            ld_keylen_q  <= 1'b0;
            ld_encdec_q  <= 1'b0;
            key_loaded_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_err_q    <= 1'b0;
            res_data_q   <= '0;
            control_q    <= CtlNop;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            key_q        <= key_d;
            blk_q        <= blk_d;
            keylen_q     <= keylen_d;
            encdec_q     <= encdec_d;
            ld_key_q     <= ld_key_d;
            ld_keylen_q  <= ld_keylen_d;
            ld_encdec_q  <= ld_encdec_d;
            key_loaded_q <= key_loaded_d;
            res_valid_q  <= res_valid_d;
            res_err_q    <= res_err_d;
            res_data_q   <= res_data_d;
            control_q    <= control_d;
            write_data_q <= write_data_d;
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.busy       = (state_q != StIdle);
    assign bus.res_valid  = res_valid_q;
    assign bus.res_err    = res_err_q;
    assign bus.res_data   = res_data_q;
    assign bus.control    = control_q;
    assign bus.write_data = write_data_q;
endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Directed bench for aes_seq_ctrl with a behavioural wrapper model on the control bus.
// The model returns FIPS-197 C.1 results for that key/block pair and a simple keyed XOR
// mix otherwise, so wrong key/block/config sequencing shows up in the returned data.
module tb_aes_seq_ctrl;
    localparam int unsigned GUARD   = 4;
    localparam int unsigned TIMEOUT = 1023;
    localparam int unsigned RD_LAT  = 1;

    localparam int LatFull = 1 + 1 + 16 + 1 + GUARD + 1 + 8 + 1 + GUARD + 1 + 16 + RD_LAT; // 55
    localparam int LatFast = 1 + 8 + 1 + GUARD + 1 + 16 + RD_LAT;                          // 32
    localparam int LatTmo  = 1 + 1 + 16 + 1 + GUARD + TIMEOUT;                             // 1046

    localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Blk2  = 128'h0;
    localparam logic [127:0] Res2  = 128'h5a5b58595e5f5c5d5253505156575455; // Blk2^C1Key^5a..

    logic clk;
    logic reset_n;
    logic hold_rdy;
    int   vectors;
    int   miscompares;

    aes_seq_ctrl_if bus ();

    aes_seq_ctrl #(
        .GUARD  (GUARD),
        .TIMEOUT(TIMEOUT),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- wrapper model ----------------
    logic [15:0]  m_key [16];
    logic [15:0]  m_blk [8];
    logic [3:0]   m_kptr;
    logic [2:0]   m_bptr;
    logic [1:0]   m_cfg;
    logic         m_ready, m_valid;
    logic [1:0]   m_rdly, m_vdly;
    logic [127:0] m_result;
    logic [7:0]   m_rd_q;
    logic [3:0]   m_rptr;
    int           n_cfg, n_keywe, n_init, wd_bad;

    function automatic logic [127:0] model_result(input logic [1:0] cfg);
        logic [127:0] khi, klo, blk;
        for (int i = 0; i < 8; i++) begin
            khi[127 - 16 * i -: 16] = m_key[i];
            klo[127 - 16 * i -: 16] = m_key[8 + i];
            blk[127 - 16 * i -: 16] = m_blk[i];
        end
        if (khi == C1Key && klo == '0 && cfg == 2'b01 && blk == C1Pt) return C1Ct;
        if (khi == C1Key && klo == '0 && cfg == 2'b00 && blk == C1Ct) return C1Pt;
        return blk ^ khi ^ (cfg[0] ? {16{8'h5a}} : {16{8'ha5}});
    endfunction

    assign bus.data_out = (bus.control == 4'd3) ? {6'b0, m_valid, m_ready} : m_rd_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) m_key[i] <= '0;
            for (int i = 0; i < 8; i++) m_blk[i] <= '0;
            m_kptr <= '0; m_bptr <= '0; m_cfg <= '0;
            m_ready <= 1'b1; m_valid <= 1'b0; m_rdly <= '0; m_vdly <= '0;
            m_result <= '0; m_rd_q <= '0; m_rptr <= '0;
            n_cfg <= 0; n_keywe <= 0; n_init <= 0; wd_bad <= 0;
        end else begin
            if (m_rdly != 0) begin
                m_rdly <= m_rdly - 2'd1;
                if (m_rdly == 2'd1 && !hold_rdy) m_ready <= 1'b1;
            end
            if (m_vdly != 0) begin
                m_vdly <= m_vdly - 2'd1;
                if (m_vdly == 2'd1) m_valid <= 1'b1;
            end
            case (bus.control)
                4'd1: begin
                    m_blk[m_bptr] <= bus.write_data;
                    m_bptr <= m_bptr + 3'd1;
                end
                4'd2: begin
                    m_key[m_kptr] <= bus.write_data;
                    m_kptr <= m_kptr + 4'd1;
                    n_keywe <= n_keywe + 1;
                end
                4'd4: begin
                    m_cfg <= bus.write_data[1:0];
                    n_cfg <= n_cfg + 1;
                end
                4'd5: begin
                    if (bus.write_data == 16'h0001) begin
                        m_ready <= 1'b0;
                        m_rdly <= 2'd2;
                        n_init <= n_init + 1;
                    end else if (bus.write_data == 16'h0002) begin
                        m_valid <= 1'b0;
                        m_vdly <= 2'd2;
                        m_result <= model_result(m_cfg);
                        m_rptr <= '0;
                    end
                end
                4'd6: begin
                    m_rd_q <= m_result[127 - 8 * int'(m_rptr) -: 8];
                    m_rptr <= m_rptr + 4'd1;
                end
                default: ;
            endcase
            if (((bus.control == 4'd0 || bus.control == 4'd3 || bus.control == 4'd6) &&
                 bus.write_data != 16'h0) || bus.control > 4'd6) begin
                wd_bad <= wd_bad + 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input string tag, input logic [127:0] k, input logic [127:0] b,
                           input logic ed, input logic rk, input int exp_lat,
                           input logic [127:0] exp_data, input logic exp_err,
                           input logic [3:0] exp_first, input int hold);
        int n;
        bus.req_key    = {k, 128'h0};
        bus.req_block  = b;
        bus.req_keylen = 1'b0;
        bus.req_encdec = ed;
        bus.req_rekey  = rk;
        bus.req_valid  = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 100) begin step(); n++; end
        chk({tag, ":req_ready"}, 256'(bus.req_ready), 256'(1));
        step();
        bus.req_valid = 1'b0;
        bus.req_rekey = 1'b0;
        chk({tag, ":first_ctrl"}, 256'(bus.control), 256'(exp_first));
        n = 1;
        while (!bus.res_valid && n < 3000) begin step(); n++; end
        chk({tag, ":latency"}, 256'(n), 256'(exp_lat));
        chk({tag, ":res_err"}, 256'(bus.res_err), 256'(exp_err));
        chk({tag, ":res_data"}, 256'(bus.res_data), 256'(exp_data));
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, ":hold"}, 256'({bus.res_valid, bus.req_ready, bus.res_err, bus.res_data}),
                256'({1'b1, 1'b0, exp_err, exp_data}));
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk({tag, ":release"}, 256'({bus.res_valid, bus.req_ready, bus.busy}), 256'(3'b010));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int c0, k0, i0, n;
        vectors = 0;
        miscompares = 0;
        hold_rdy = 1'b0;
        reset_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_key = '0; bus.req_block = '0;
        bus.req_keylen = 1'b0; bus.req_encdec = 1'b0; bus.req_rekey = 1'b0;
        bus.res_ready = 1'b0;
        #1;
        chk("reset:outs", 256'({bus.control, bus.write_data, bus.res_valid, bus.res_err,
                                bus.busy, bus.req_ready}),
            256'({4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1}));
        chk("reset:res_data", 256'(bus.res_data), 256'(0));
        step(); step();
        reset_n = 1'b1;
        step();

        // 1: first job always rekeys
        c0 = n_cfg; k0 = n_keywe;
        run_job("t1_enc", C1Key, C1Pt, 1'b1, 1'b0, LatFull, C1Ct, 1'b0, 4'd4, 0);
        chk("t1:cfg_writes", 256'(n_cfg - c0), 256'(1));
        chk("t1:key_writes", 256'(n_keywe - k0), 256'(16));

        // 2: unchanged key/config -> no CFG/KEY/INIT traffic
        c0 = n_cfg; k0 = n_keywe; i0 = n_init;
        run_job("t2_fast", C1Key, Blk2, 1'b1, 1'b0, LatFast, Res2, 1'b0, 4'd1, 0);
        chk("t2:no_setup", 256'({n_cfg - c0, n_keywe - k0, n_init - i0}), 256'(0));

        // 3: encdec change reissues setup; forced rekey with same settings does too
        c0 = n_cfg;
        run_job("t3_dec", C1Key, C1Ct, 1'b0, 1'b0, LatFull, C1Pt, 1'b0, 4'd4, 0);
        run_job("t3_rekey", C1Key, C1Ct, 1'b0, 1'b1, LatFull, C1Pt, 1'b0, 4'd4, 0);
        chk("t3:cfg_writes", 256'(n_cfg - c0), 256'(2));

        // 4: ready never rises -> timeout error; the following job must reload the key
        hold_rdy = 1'b1;
        run_job("t4_tmo", C1Key, C1Ct, 1'b0, 1'b1, LatTmo, 128'h0, 1'b1, 4'd4, 0);
        hold_rdy = 1'b0;
        c0 = n_cfg;
        run_job("t4_after", C1Key, C1Ct, 1'b0, 1'b0, LatFull, C1Pt, 1'b0, 4'd4, 0);
        chk("t4:rekeyed", 256'(n_cfg - c0), 256'(1));

        // 5: result held while res_ready stays low
        run_job("t5_hold", C1Key, C1Ct, 1'b0, 1'b0, LatFast, C1Pt, 1'b0, 4'd1, 20);

        // 6: reset during READ
        bus.req_key = {C1Key, 128'h0}; bus.req_block = C1Ct;
        bus.req_keylen = 1'b0; bus.req_encdec = 1'b0; bus.req_rekey = 1'b0;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        n = 0;
        while (bus.control != 4'd6 && n < 200) begin step(); n++; end
        chk("t6:reached_read", 256'(bus.control), 256'(6));
        step(); step(); step();
        reset_n = 1'b0;
        #1;
        chk("t6:rst_outs", 256'({bus.control, bus.write_data, bus.res_valid, bus.res_err,
                                 bus.busy, bus.req_ready}),
            256'({4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1}));
        chk("t6:rst_data", 256'(bus.res_data), 256'(0));
        step();
        chk("t6:rst_hold", 256'({bus.res_valid, bus.busy}), 256'(0));
        reset_n = 1'b1;
        step();
        run_job("t6_fresh", C1Key, C1Ct, 1'b0, 1'b0, LatFull, C1Pt, 1'b0, 4'd4, 0);

        chk("bus:wd_zero", 256'(wd_bad), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
